// File: rtl/axum_uart.sv
// axum_uart: memory-mapped 8N1 UART peripheral for the SoC data bus.
//
// Decodes addr[9:2] inside a 1 kB window. Outgoing bytes are queued in a
// TX FIFO and shifted out LSB first on uart_tx_o. Incoming bytes are caught
// in a one-byte holding register. A registered level interrupt is raised
// for TX-idle and/or RX-valid.
//
// Optional build macro: AXUM_UART_RX_EN builds the receive path (synchroniser,
// RX FSM, holding register). Without it, uart_rx_i is ignored and the RX
// status bits read as zero.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   uart_req_i     bus request, one cycle per access
//   uart_we_i      1 = write
//   uart_be_i      byte enables
//   uart_addr_i    byte address (only [9:2] decoded)
//   uart_wdata_i   write data
//   uart_rvalid_o  response valid, one cycle after the request
//   uart_rdata_o   read data, valid with rvalid
//   uart_err_o     error response, valid with rvalid
//   uart_intr_o    level interrupt
//   uart_tx_o      serial out, idle high
//   uart_rx_i      serial in, asynchronous
module axum_uart #(
  parameter int          DataWidth    = 32,
  parameter int          AddressWidth = 32,
  parameter int          TxDepth      = 8,
  parameter logic [15:0] ClkDivReset  = 16'd434
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    uart_req_i,
  input  logic                    uart_we_i,
  input  logic [3:0]              uart_be_i,
  input  logic [AddressWidth-1:0] uart_addr_i,
  input  logic [DataWidth-1:0]    uart_wdata_i,
  output logic                    uart_rvalid_o,
  output logic [DataWidth-1:0]    uart_rdata_o,
  output logic                    uart_err_o,
  output logic                    uart_intr_o,
  output logic                    uart_tx_o,
  input  logic                    uart_rx_i
);

  localparam int             PtrW      = $clog2(TxDepth);
  localparam logic [PtrW:0]  FullCount = (PtrW + 1)'(TxDepth);

  localparam logic [7:0] RegTxData = 8'h00;
  localparam logic [7:0] RegRxData = 8'h01;
  localparam logic [7:0] RegStatus = 8'h02;
  localparam logic [7:0] RegDiv    = 8'h03;
  localparam logic [7:0] RegIe     = 8'h04;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Bus decode
  logic [7:0] reg_sel;
  logic       bus_wr;
  logic       bus_rd;
  assign reg_sel = uart_addr_i[9:2];
  assign bus_wr  = uart_req_i & uart_we_i;
  assign bus_rd  = uart_req_i & ~uart_we_i;

  // Control registers
  logic [15:0] div_reg;
  logic [1:0]  ie_reg;
  logic [15:0] div_wr;

  // TX FIFO
  logic [7:0]      fifo_mem [TxDepth];
  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [PtrW:0]   count_reg;
  logic            tx_full;
  logic            tx_empty;
  logic            tx_push;
  logic            tx_pop;

  // TX FSM
  tx_state_t   tx_state_reg;
  logic [15:0] tx_cnt_reg;
  logic [2:0]  tx_bit_reg;
  logic [7:0]  tx_shift_reg;
  logic        tx_line_reg;
  logic        tx_bit_end;
  logic        tx_busy;

  // RX-side status seen by the register file
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic [7:0] rx_byte;

  // Bus response
  logic                 rvalid_reg;
  logic [DataWidth-1:0] rdata_reg;
  logic                 err_reg;
  logic [DataWidth-1:0] rdata_next;
  logic                 err_next;
  logic                 intr_reg;

  assign tx_full    = (count_reg == FullCount);
  assign tx_empty   = (count_reg == '0);
  assign tx_busy    = (tx_state_reg != TX_IDLE);
  assign tx_bit_end = (tx_cnt_reg == 16'd0);
  // Fullness is judged before any same-cycle pop, so a push to a full FIFO
  // is rejected even when a pop coincides.
  assign tx_push    = bus_wr & (reg_sel == RegTxData) & uart_be_i[0] & ~tx_full;
  // Head is consumed when a frame starts: from IDLE, or straight out of STOP.
  assign tx_pop     = ~tx_empty &
                      ((tx_state_reg == TX_IDLE) | ((tx_state_reg == TX_STOP) & tx_bit_end));

  // DIV write merge with per-byte enables; too-small divisors are clamped.
  always_comb begin
    div_wr = div_reg;
    if (uart_be_i[0]) div_wr[7:0]  = uart_wdata_i[7:0];
    if (uart_be_i[1]) div_wr[15:8] = uart_wdata_i[15:8];
    if (div_wr < 16'd4) div_wr = 16'd4;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_reg <= ClkDivReset;
      ie_reg  <= 2'b00;
    end else if (bus_wr) begin
      if (reg_sel == RegDiv) div_reg <= div_wr;
      if ((reg_sel == RegIe) && uart_be_i[0]) ie_reg <= uart_wdata_i[1:0];
    end
  end

  // FIFO storage has no reset; only the pointers and count are cleared.
  always_ff @(posedge clk_i) begin
    if (tx_push) fifo_mem[wr_ptr_reg] <= uart_wdata_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (tx_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (tx_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // TX FSM. Every state lasts DIV clocks; the counter is reloaded from
  // div_reg only at bit boundaries so a DIV change never cuts a bit short.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= 16'd0;
      tx_bit_reg   <= 3'd0;
      tx_shift_reg <= 8'h00;
      tx_line_reg  <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_state_reg <= TX_START;
            tx_shift_reg <= fifo_mem[rd_ptr_reg];
            tx_cnt_reg   <= div_reg - 16'd1;
            tx_line_reg  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state_reg <= TX_DATA;
            tx_bit_reg   <= 3'd0;
            tx_line_reg  <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_cnt_reg   <= div_reg - 16'd1;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt_reg <= div_reg - 16'd1;
            if (tx_bit_reg == 3'd7) begin
              tx_state_reg <= TX_STOP;
              tx_line_reg  <= 1'b1;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              tx_line_reg  <= tx_shift_reg[0];
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            if (!tx_empty) begin
              // Chain straight into the next frame with no idle gap.
              tx_state_reg <= TX_START;
              tx_shift_reg <= fifo_mem[rd_ptr_reg];
              tx_cnt_reg   <= div_reg - 16'd1;
              tx_line_reg  <= 1'b0;
            end else begin
              tx_state_reg <= TX_IDLE;
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 16'd1;
          end
        end
        default: begin
          tx_state_reg <= TX_IDLE;
          tx_line_reg  <= 1'b1;
        end
      endcase
    end
  end

`ifdef AXUM_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state_reg;
  logic        rx_sync1_reg;
  logic        rx_sync2_reg;
  logic        rx_prev_reg;
  logic [15:0] rx_cnt_reg;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg;
  logic [7:0]  rx_byte_reg;
  logic        rx_valid_reg;
  logic        rx_overrun_reg;
  logic        rx_frame_err_reg;
  logic        rx_data_rd;
  logic        status_rd;

  assign rx_data_rd = bus_rd & (reg_sel == RegRxData);
  assign status_rd  = bus_rd & (reg_sel == RegStatus);

  // Clear-on-read is written first so that a same-cycle set or load,
  // written later in the block, takes priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_reg     <= RX_IDLE;
      rx_sync1_reg     <= 1'b1;
      rx_sync2_reg     <= 1'b1;
      rx_prev_reg      <= 1'b1;
      rx_cnt_reg       <= 16'd0;
      rx_bit_reg       <= 3'd0;
      rx_shift_reg     <= 8'h00;
      rx_byte_reg      <= 8'h00;
      rx_valid_reg     <= 1'b0;
      rx_overrun_reg   <= 1'b0;
      rx_frame_err_reg <= 1'b0;
    end else begin
      rx_sync1_reg <= uart_rx_i;
      rx_sync2_reg <= rx_sync1_reg;
      rx_prev_reg  <= rx_sync2_reg;
      if (rx_data_rd) rx_valid_reg <= 1'b0;
      if (status_rd) begin
        rx_overrun_reg   <= 1'b0;
        rx_frame_err_reg <= 1'b0;
      end
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_prev_reg && !rx_sync2_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= (div_reg >> 1) - 16'd1;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == 16'd0) begin
            if (rx_sync2_reg) begin
              rx_state_reg <= RX_IDLE;   // glitch, not a real start bit
            end else begin
              rx_state_reg <= RX_DATA;
              rx_bit_reg   <= 3'd0;
              rx_cnt_reg   <= div_reg - 16'd1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == 16'd0) begin
            rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
            rx_cnt_reg   <= div_reg - 16'd1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
            else rx_bit_reg <= rx_bit_reg + 3'd1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == 16'd0) begin
            rx_state_reg <= RX_IDLE;
            if (!rx_sync2_reg) begin
              rx_frame_err_reg <= 1'b1;
            end else if (rx_valid_reg && !rx_data_rd) begin
              rx_overrun_reg <= 1'b1;
            end else begin
              // A read in this same cycle returns the old byte and frees
              // the slot, so the new byte loads without an overrun.
              rx_byte_reg  <= rx_shift_reg;
              rx_valid_reg <= 1'b1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 16'd1;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid     = rx_valid_reg;
  assign rx_overrun   = rx_overrun_reg;
  assign rx_frame_err = rx_frame_err_reg;
  assign rx_byte      = rx_byte_reg;
`else
  logic unused_rx;
  assign unused_rx    = uart_rx_i;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_byte      = 8'h00;
`endif

  // Address bits outside the decoded window and unused data lanes.
  logic unused_bus;
  assign unused_bus = ^{uart_addr_i[AddressWidth-1:10], uart_addr_i[1:0],
                        uart_wdata_i[DataWidth-1:16], uart_be_i[3:2]};

  // Read mux and error decode. The byte field of RXDATA reads zero once the
  // holding register has been consumed.
  always_comb begin
    rdata_next = '0;
    err_next   = 1'b0;
    case (reg_sel)
      RegTxData: err_next   = uart_we_i & uart_be_i[0] & tx_full;
      RegRxData: rdata_next = {rx_valid, 23'b0, (rx_valid ? rx_byte : 8'h00)};
      RegStatus: rdata_next = {26'b0, rx_frame_err, rx_overrun, rx_valid,
                               tx_busy, tx_empty, tx_full};
      RegDiv:    rdata_next = {16'b0, div_reg};
      RegIe:     rdata_next = {30'b0, ie_reg};
      default:   err_next   = 1'b1;
    endcase
    if (uart_we_i) rdata_next = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      intr_reg   <= 1'b0;
    end else begin
      rvalid_reg <= uart_req_i;
      rdata_reg  <= uart_req_i ? rdata_next : '0;
      err_reg    <= uart_req_i & err_next;
      intr_reg   <= (ie_reg[0] & tx_empty & ~tx_busy) | (ie_reg[1] & rx_valid);
    end
  end

  assign uart_rvalid_o = rvalid_reg;
  assign uart_rdata_o  = rdata_reg;
  assign uart_err_o    = err_reg;
  assign uart_intr_o   = intr_reg;
  assign uart_tx_o     = tx_line_reg;

endmodule
